// File: rtl/alarm_pkg.sv
// ============================================================================
// Module : alarm_pkg
// Brief  : Shared types, default thresholds and persistence helper for the
//          alarm status monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } qual_state_t;

  localparam logic [11:0] BATT_LOW_TH_DEF = 12'h800;
  localparam logic [11:0] BATT_HYST_DEF   = 12'h040;
  localparam logic [10:0] OVR_SPD_TH_DEF  = 11'd1536;
  localparam logic [10:0] SPD_HYST_DEF    = 11'd128;
  localparam logic [10:0] MOV_TH_DEF      = 11'd64;
  localparam int          PERSIST_DEF     = 50000;

  // Shortens the qualification window so simulations stay short.
  function automatic int persist_cnt(input int persist, input int fast_sim);
    return (fast_sim != 0) ? 4 : persist;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_flag_qual.sv
// ============================================================================
// Module : alarm_flag_qual
// Brief  : Two-state persistence qualifier; the flag toggles only after its
//          condition holds for PERSIST_CNT consecutive cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_flag_qual
  import alarm_pkg::*;
#(
  parameter int PERSIST_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_cond,
  input  logic clr_cond,
  input  logic force_clr,
  input  logic latch,
  output logic flag
);

  localparam int             CW       = (PERSIST_CNT > 1) ? $clog2(PERSIST_CNT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(PERSIST_CNT - 1);

  qual_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cond;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    // A latched alarm never sees its clear condition.
    cond    = (state_q == IDLE) ? set_cond : (clr_cond & ~latch);
    if (force_clr) begin
      state_d = IDLE;
    end else if (cond) begin
      if (cnt_q == CNT_LAST) begin
        state_d = (state_q == IDLE) ? ALARM : IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flag = (state_q == ALARM);

endmodule

`default_nettype wire

// File: rtl/alarm_status_mon.sv
// ============================================================================
// Module : alarm_status_mon
// Brief  : Qualified battery-low, over-speed and moving flags for the piezo
//          driver. Define ALARM_BATT_LATCH_EN to make batt_low sticky until reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_status_mon
  import alarm_pkg::*;
#(
  parameter logic [11:0] BATT_LOW_TH = BATT_LOW_TH_DEF,
  parameter logic [11:0] BATT_HYST   = BATT_HYST_DEF,
  parameter logic [10:0] OVR_SPD_TH  = OVR_SPD_TH_DEF,
  parameter logic [10:0] SPD_HYST    = SPD_HYST_DEF,
  parameter logic [10:0] MOV_TH      = MOV_TH_DEF,
  parameter int          PERSIST     = PERSIST_DEF,
  parameter int          FAST_SIM    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic        batt_vld,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  input  logic        en_steer,
  input  logic        pwr_up,
  output logic        batt_low,
  output logic        ovr_spd,
  output logic        moving
);

  localparam int          PERSIST_CNT = persist_cnt(PERSIST, FAST_SIM);
  localparam logic [12:0] BATT_CLR_TH = {1'b0, BATT_LOW_TH} + {1'b0, BATT_HYST};
  localparam logic [10:0] OVR_CLR_TH  = OVR_SPD_TH - SPD_HYST;

`ifdef ALARM_BATT_LATCH_EN
  localparam logic BATT_LATCH = 1'b1;
`else
  localparam logic BATT_LATCH = 1'b0;
`endif

  logic [11:0]        batt_reg_q, batt_reg_d;
  logic [10:0]        spd_mag_q, spd_mag_d;
  logic               moving_q, moving_d;
  logic signed [11:0] sum_w;
  logic signed [11:0] avg_w;

  assign batt_reg_d = batt_vld ? batt : batt_reg_q;

  assign sum_w = $signed({lft_spd[10], lft_spd}) + $signed({rght_spd[10], rght_spd});
  assign avg_w = sum_w >>> 1;
  // avg is within -1024..1023, so the 11-bit negate of -1024 yields 1024.
  assign spd_mag_d = avg_w[11] ? (~avg_w[10:0] + 11'd1) : avg_w[10:0];

  assign moving_d = en_steer & pwr_up & (spd_mag_q >= MOV_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_reg_q <= 12'hFFF;
      spd_mag_q  <= '0;
      moving_q   <= 1'b0;
    end else begin
      batt_reg_q <= batt_reg_d;
      spd_mag_q  <= spd_mag_d;
      moving_q   <= moving_d;
    end
  end

  alarm_flag_qual #(.PERSIST_CNT(PERSIST_CNT)) u_batt_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_cond  (batt_reg_q < BATT_LOW_TH),
    .clr_cond  ({1'b0, batt_reg_q} >= BATT_CLR_TH),
    .force_clr (1'b0),
    .latch     (BATT_LATCH),
    .flag      (batt_low)
  );

  alarm_flag_qual #(.PERSIST_CNT(PERSIST_CNT)) u_ovr_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_cond  (spd_mag_q > OVR_SPD_TH),
    .clr_cond  (spd_mag_q <= OVR_CLR_TH),
    .force_clr (~pwr_up),
    .latch     (1'b0),
    .flag      (ovr_spd)
  );

  assign moving = moving_q;

endmodule

`default_nettype wire
